// File: rtl/comm_link_seq_if.sv
// -----------------------------------------------------------------------------
// comm_link_seq_if
// Bundle of the per-sample signals exchanged between the comm-loop sequencer
// and its surroundings (sample source, PCM encoder, PCM decoder, statistics).
//
// Modports:
//   master : the system side. It drives sample_tick, data_in and dec_data,
//            and observes every sequencer output.
//   slave  : the sequencer side (comm_link_seq). It receives the strobe, the
//            raw sample and the recovered sample. It drives tx_load, tx_data,
//            dec_enable, rx_valid, rx_data, busy, overrun, frame_cnt and
//            err_cnt.
//
// Parameter CNT_W must match the CNT_W of the attached comm_link_seq.
// -----------------------------------------------------------------------------
interface comm_link_seq_if #(
  parameter int CNT_W = 16
);
  logic             sample_tick;
  logic [7:0]       data_in;
  logic [7:0]       dec_data;
  logic             tx_load;
  logic [7:0]       tx_data;
  logic             dec_enable;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output sample_tick, data_in, dec_data,
    input  tx_load, tx_data, dec_enable, rx_valid, rx_data,
           busy, overrun, frame_cnt, err_cnt
  );

  modport slave (
    input  sample_tick, data_in, dec_data,
    output tx_load, tx_data, dec_enable, rx_valid, rx_data,
           busy, overrun, frame_cnt, err_cnt
  );
endinterface

// File: rtl/comm_link_seq.sv
// -----------------------------------------------------------------------------
// comm_link_seq
// Per-sample frame sequencer for the PCM -> Hamming -> FSK -> demod -> PCM
// decode loop. Each accepted sample_tick does the following, in order:
//   1. Latches data_in into tx_data and pulses tx_load.
//   2. Waits the link latency.
//   3. Pulses dec_enable.
//   4. Waits the decoder latency, then captures dec_data into rx_data and
//      pulses rx_valid.
// The latency from sample_tick to rx_valid is LINK_LAT + DEC_LAT + 2 cycles.
//
// Ports:
//   sysclk : system clock; all logic runs on its rising edge.
//   reset  : synchronous, active-low reset.
//   bus    : comm_link_seq_if.slave. It carries:
//              - the sample strobe and the raw and recovered samples;
//              - the load and enable pulses;
//              - the captured sample and the busy/overrun flags;
//              - the saturating frame and bit-error counters.
//
// Parameters:
//   LINK_LAT : cycles from tx_load to the dec_enable cycle (2..1023).
//   DEC_LAT  : cycles from dec_enable to dec_data valid (1..15).
//   CNT_W    : width of the statistic counters (>= 4).
//
// Optional feature, macro LOOPBACK_CHECK_EN:
//   When the macro is defined, each frame adds popcount(tx_data ^ dec_data)
//   to err_cnt in the capture cycle, saturating.
//   When the macro is not defined, err_cnt is constant 0 and no comparator
//   logic exists.
// -----------------------------------------------------------------------------
module comm_link_seq #(
  parameter int LINK_LAT = 64,
  parameter int DEC_LAT  = 2,
  parameter int CNT_W    = 16
) (
  input  logic           sysclk,
  input  logic           reset,
  comm_link_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    LINK = 3'd2,
    DEC  = 3'd3,
    CAPT = 3'd4
  } state_t;

  // LINK spans LINK_LAT-1 cycles (counter 0..LINK_LAT-2). The counter would
  // reach LINK_LAT-1 on the transition to DEC. That places dec_enable exactly
  // LINK_LAT cycles after the tx_load cycle.
  localparam logic [9:0]       LINK_LAST = 10'(LINK_LAT - 2);
  localparam logic [9:0]       DEC_LAST  = 10'(DEC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_r;
  logic [9:0]       wait_r;
  logic             tx_load_r;
  logic [7:0]       tx_data_r;
  logic             dec_enable_r;
  logic             rx_valid_r;
  logic [7:0]       rx_data_r;
  logic             busy_r;
  logic             overrun_r;
  logic [CNT_W-1:0] frame_cnt_r;

  // Saturating increment for the frame counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

`ifdef LOOPBACK_CHECK_EN
  logic [CNT_W-1:0] err_cnt_r;

  // Number of differing bits between the sent and the recovered sample.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Saturating add of a 0..8 error count onto the error counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
    if (s[CNT_W]) begin
      return CNT_MAX;
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction
`endif

  // Frame sequencer FSM with registered pulses, flags and statistics.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_r      <= IDLE;
      wait_r       <= 10'd0;
      tx_load_r    <= 1'b0;
      tx_data_r    <= 8'd0;
      dec_enable_r <= 1'b0;
      rx_valid_r   <= 1'b0;
      rx_data_r    <= 8'd0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      frame_cnt_r  <= {CNT_W{1'b0}};
`ifdef LOOPBACK_CHECK_EN
      err_cnt_r    <= {CNT_W{1'b0}};
`endif
    end else begin
      // Pulse outputs default low; the state that owns a pulse raises it.
      tx_load_r    <= 1'b0;
      dec_enable_r <= 1'b0;
      rx_valid_r   <= 1'b0;

      // A tick during an active frame is dropped and flagged (sticky).
      if (bus.sample_tick && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (bus.sample_tick) begin
            tx_data_r <= bus.data_in;
            tx_load_r <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= LOAD;
          end
        end
        LOAD: begin
          wait_r  <= 10'd0;
          state_r <= LINK;
        end
        LINK: begin
          if (wait_r == LINK_LAST) begin
            dec_enable_r <= 1'b1;
            state_r      <= DEC;
          end else begin
            wait_r <= wait_r + 10'd1;
          end
        end
        DEC: begin
          wait_r  <= 10'd0;
          state_r <= CAPT;
        end
        CAPT: begin
          if (wait_r == DEC_LAST) begin
            rx_data_r   <= bus.dec_data;
            rx_valid_r  <= 1'b1;
            frame_cnt_r <= sat_inc(frame_cnt_r);
`ifdef LOOPBACK_CHECK_EN
            err_cnt_r   <= sat_add(err_cnt_r, popcount8(tx_data_r ^ bus.dec_data));
`endif
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            wait_r <= wait_r + 10'd1;
          end
        end
        default: begin
          wait_r  <= 10'd0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_load    = tx_load_r;
  assign bus.tx_data    = tx_data_r;
  assign bus.dec_enable = dec_enable_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.rx_data    = rx_data_r;
  assign bus.busy       = busy_r;
  assign bus.overrun    = overrun_r;
  assign bus.frame_cnt  = frame_cnt_r;
`ifdef LOOPBACK_CHECK_EN
  assign bus.err_cnt    = err_cnt_r;
`else
  assign bus.err_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_comm_link_seq.sv
// -----------------------------------------------------------------------------
// tb_comm_link_seq
// Self-checking bench for comm_link_seq. Two instances are built:
//   - a main instance with LINK_LAT=64, DEC_LAT=2 and CNT_W=16;
//   - a small instance with LINK_LAT=2, DEC_LAT=1 and CNT_W=4, used for the
//     counter-saturation checks.
// A frame-level reference model predicts every output of the main instance
// on every cycle. The model works from the absolute cycle of the accepted
// tick. Directed steps add explicit latency and boundary checks.
// Honours LOOPBACK_CHECK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_comm_link_seq;
  localparam int LL  = 64;
  localparam int DL  = 2;
  localparam int CW  = 16;
  localparam int LL2 = 2;
  localparam int DL2 = 1;
  localparam int CW2 = 4;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;

  comm_link_seq_if #(.CNT_W(CW))  bus  ();
  comm_link_seq_if #(.CNT_W(CW2)) bus2 ();

  comm_link_seq #(.LINK_LAT(LL),  .DEC_LAT(DL),  .CNT_W(CW))  dut     (.sysclk(sysclk), .reset(reset), .bus(bus));
  comm_link_seq #(.LINK_LAT(LL2), .DEC_LAT(DL2), .CNT_W(CW2)) dut_sat (.sysclk(sysclk), .reset(reset), .bus(bus2));

  always #5 sysclk = ~sysclk;

  int n_assert = 0;
  int n_fail   = 0;
  int n        = 0;   // index of the current cycle

  // Reference model state, frame-level view
  bit       m_active = 1'b0;
  int       m_t0     = 0;     // cycle in which the accepted tick was presented
  bit [7:0] m_tx     = 8'd0;
  bit [7:0] m_rx     = 8'd0;
  bit       m_ovr    = 1'b0;
  int       m_frame  = 0;
  int       m_err    = 0;
  bit       e_txload = 1'b0;
  bit       e_dec    = 1'b0;
  bit       e_rxv    = 1'b0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  // Advance one cycle. Predict the outputs from this cycle's inputs, then
  // compare every main-instance output just after the edge.
  task automatic step();
    if (!reset) begin
      m_active = 1'b0; m_tx = 8'd0; m_rx = 8'd0; m_ovr = 1'b0;
      m_frame = 0; m_err = 0; e_txload = 1'b0; e_dec = 1'b0; e_rxv = 1'b0;
    end else begin
      e_txload = 1'b0; e_dec = 1'b0; e_rxv = 1'b0;
      if (m_active) begin
        if (bus.sample_tick) m_ovr = 1'b1;
        if (n + 1 == m_t0 + 1 + LL) e_dec = 1'b1;
        if (n + 1 == m_t0 + LL + DL + 2) begin
          e_rxv    = 1'b1;
          m_rx     = bus.dec_data;
          m_frame  = imin(m_frame + 1, (1 << CW) - 1);
`ifdef LOOPBACK_CHECK_EN
          m_err    = imin(m_err + $countones(m_tx ^ bus.dec_data), (1 << CW) - 1);
`endif
          m_active = 1'b0;
        end
      end else if (bus.sample_tick) begin
        m_active = 1'b1;
        m_t0     = n;
        m_tx     = bus.data_in;
        e_txload = 1'b1;
      end
    end
    @(posedge sysclk);
    #1;
    n++;
    chk("tx_load",    32'(bus.tx_load),    32'(e_txload));
    chk("tx_data",    32'(bus.tx_data),    32'(m_tx));
    chk("dec_enable", 32'(bus.dec_enable), 32'(e_dec));
    chk("rx_valid",   32'(bus.rx_valid),   32'(e_rxv));
    chk("rx_data",    32'(bus.rx_data),    32'(m_rx));
    chk("busy",       32'(bus.busy),       32'(m_active));
    chk("overrun",    32'(bus.overrun),    32'(m_ovr));
    chk("frame_cnt",  32'(bus.frame_cnt),  32'(m_frame));
    chk("err_cnt",    32'(bus.err_cnt),    32'(m_err));
  endtask

  // Tick one sample in and run until rx_valid. Latencies are measured from
  // the tick cycle. The task leaves the bench in the rx_valid cycle.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] dd,
                           output int lat_load, output int lat_dec, output int lat_rx);
    int start;
    int budget;
    lat_load = -1; lat_dec = -1; lat_rx = -1;
    bus.sample_tick = 1'b1; bus.data_in = d; bus.dec_data = dd;
    start = n;
    step();
    bus.sample_tick = 1'b0;
    budget = LL + DL + 20;
    while (lat_rx < 0 && budget > 0) begin
      if (bus.tx_load && lat_load < 0) lat_load = n - start;
      if (bus.dec_enable && lat_dec < 0) lat_dec = n - start;
      if (bus.rx_valid) lat_rx = n - start;
      else begin step(); budget--; end
    end
    chk("frame_done_in_budget", 32'(lat_rx >= 0), 32'd1);
  endtask

  // Reset for one cycle (the model follows the reset input).
  task automatic pulse_reset();
    reset = 1'b0; step(); reset = 1'b1;
  endtask

  initial begin
    int ll, ld, lr, loads, decs, budget, start;
    logic [7:0] d;

    bus.sample_tick = 1'b0; bus.data_in = 8'd0; bus.dec_data = 8'd0;
    bus2.sample_tick = 1'b0; bus2.data_in = 8'd0; bus2.dec_data = 8'd0;

    // Reset state
    reset = 1'b0;
    repeat (3) step();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    reset = 1'b1;
    repeat (7) step();

    // Single frame 0xA5: load +1, dec_enable +65, rx_valid +68
    run_frame(8'hA5, 8'h3C, ll, ld, lr);
    chk("single_lat_load", 32'(ll), 32'd1);
    chk("single_lat_dec",  32'(ld), 32'd65);
    chk("single_lat_rx",   32'(lr), 32'd68);
    chk("single_rx_data",  32'(bus.rx_data), 32'h3C);
    chk("single_tx_data",  32'(bus.tx_data), 32'hA5);
    chk("single_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    step();

    // Overrun: second tick 20 cycles after the first
    pulse_reset();
    bus.sample_tick = 1'b1; bus.data_in = 8'h11; start = n;
    loads = 0;
    step();
    bus.sample_tick = 1'b0;
    budget = 200;
    while (!bus.rx_valid && budget > 0) begin
      if (bus.tx_load) loads++;
      bus.sample_tick = (n - start == 20);
      bus.data_in     = (n - start == 20) ? 8'h22 : 8'h11;
      bus.dec_data    = 8'($urandom);
      step();
      budget--;
    end
    chk("ovr_done_in_budget", 32'(budget > 0), 32'd1);
    chk("ovr_flag",      32'(bus.overrun),   32'd1);
    chk("ovr_one_load",  32'(loads),         32'd1);
    chk("ovr_tx_kept",   32'(bus.tx_data),   32'h11);
    chk("ovr_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    repeat (5) step();
    chk("ovr_sticky",    32'(bus.overrun),   32'd1);

    // Back-to-back: second tick in the rx_valid cycle
    pulse_reset();
    run_frame(8'h5A, 8'h5A, ll, ld, lr);
    run_frame(8'hC3, 8'h3C, ll, ld, lr);
    chk("b2b_lat_load",  32'(ll), 32'd1);
    chk("b2b_lat_rx",    32'(lr), 32'd68);
    chk("b2b_frame_cnt", 32'(bus.frame_cnt), 32'd2);
    chk("b2b_overrun",   32'(bus.overrun),   32'd0);
    step();

    // Loopback comparison: 0xFF sent, 0x0F recovered
    pulse_reset();
    run_frame(8'hFF, 8'h0F, ll, ld, lr);
`ifdef LOOPBACK_CHECK_EN
    chk("loopback_err_cnt", 32'(bus.err_cnt), 32'd4);
`else
    chk("loopback_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
    step();

    // Reset asserted for one cycle, 40 cycles into the link wait
    bus.sample_tick = 1'b1; bus.data_in = 8'h77;
    step();
    bus.sample_tick = 1'b0;
    repeat (41) step();
    pulse_reset();
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    chk("midrst_tx_data",   32'(bus.tx_data),   32'd0);
    chk("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    decs = 0;
    for (int k = 0; k < LL + 10; k++) begin
      step();
      if (bus.dec_enable || bus.rx_valid) decs++;
    end
    chk("midrst_no_dec", 32'(decs), 32'd0);
    run_frame(8'h99, 8'h66, ll, ld, lr);
    chk("midrst_clean_lat", 32'(lr), 32'd68);
    chk("midrst_clean_cnt", 32'(bus.frame_cnt), 32'd1);

    // Randomised traffic; dec_data changes every cycle
    for (int k = 0; k < 900; k++) begin
      bus.sample_tick = ($urandom_range(0, 29) == 0);
      bus.data_in     = 8'($urandom);
      bus.dec_data    = 8'($urandom);
      step();
    end
    bus.sample_tick = 1'b0;
    repeat (LL + DL + 4) step();

    // Saturation of 4-bit counters on the small instance: 17 frames
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      bus2.sample_tick = 1'b1; bus2.data_in = d; bus2.dec_data = ~d;
      start = n;
      step();
      bus2.sample_tick = 1'b0;
      budget = 20;
      while (!bus2.rx_valid && budget > 0) begin step(); budget--; end
      chk("sat_lat_rx",    32'(n - start), 32'(LL2 + DL2 + 2));
      chk("sat_frame_cnt", 32'(bus2.frame_cnt), 32'(imin(i + 1, 15)));
`ifdef LOOPBACK_CHECK_EN
      chk("sat_err_cnt",   32'(bus2.err_cnt), 32'(imin(8 * (i + 1), 15)));
`else
      chk("sat_err_cnt",   32'(bus2.err_cnt), 32'd0);
`endif
    end
    repeat (4) step();
    chk("sat_frame_held", 32'(bus2.frame_cnt), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/comm_link_seq.md
Name: comm_link_seq

Overview:
- Frame sequencer for the PCM -> Hamming -> FSK -> decode -> PCM-decode loop of the comm system.
- On each sample tick it latches one 8-bit sample into the encoder path and waits a fixed link latency.
- It then pulses the decoder enable and captures the recovered sample.
- It keeps frame, overrun and bit-error statistics; it replaces free-running enable generation with a deterministic per-sample schedule.

Parameters:
- LINK_LAT, 64: sysclk cycles from tx_load to decoder input valid (modulator plus demodulator latency); legal range 2..1023.
- DEC_LAT, 2: sysclk cycles from the dec_enable pulse to dec_data valid; legal range 1..15.
- CNT_W, 16: width of the statistic counters.

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- sample_tick  in  1  one-cycle pulse per sample period (8 kHz strobe already synchronised to sysclk).
- data_in  in  8  raw sample to transmit.
- dec_data  in  8  recovered sample from the PCM decoder.
- tx_load  out  1  one-cycle pulse; the encoder path captures tx_data.
- tx_data  out  8  latched sample driving the PCM encoder.
- dec_enable  out  1  one-cycle decoder enable pulse.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- rx_data  out  8  captured recovered sample.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky; set when sample_tick arrives while busy.
- frame_cnt  out  CNT_W  frames completed.
- err_cnt  out  CNT_W  accumulated bit errors (see Optional Feature).

Behaviour:
- Reset: synchronous, active-low, sampled on sysclk. Every output, counter and register clears to 0; state goes to IDLE. Reset asserted mid-frame aborts the frame immediately, with no rx_valid and no frame_cnt increment.
- States: IDLE, LOAD, LINK, DEC, CAPT.
- IDLE: on sample_tick, register data_in into tx_data and go to LOAD.
- LOAD: tx_load=1 for exactly this cycle; clear the wait counter; go to LINK.
- LINK: increment the wait counter. When it reaches LINK_LAT-1, go to DEC. This makes the dec_enable cycle exactly LINK_LAT cycles after the tx_load cycle.
- DEC: dec_enable=1 for this cycle only; clear the wait counter; go to CAPT.
- CAPT: count DEC_LAT cycles. On the last cycle, register dec_data into rx_data and go to IDLE.
  - rx_valid pulses high in the first IDLE cycle, together with the new rx_data.
  - frame_cnt increments in that same cycle.
- Total latency, sample_tick to rx_valid: LINK_LAT + DEC_LAT + 2 cycles.
- sample_tick while busy: the sample is dropped, overrun is set (sticky until reset), and the current frame is unaffected.
- sample_tick in the same cycle that rx_valid pulses (state IDLE): accepted normally. Back-to-back frames are legal.
- tx_data holds its value between loads. rx_data holds until the next capture.
- Counters saturate at all-ones and do not wrap.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: LOOPBACK_CHECK_EN.
- Defined:
  - In CAPT's final cycle, compute the popcount of (tx_data XOR dec_data), 0..8.
  - Add it to err_cnt, saturating. The update is visible in the rx_valid cycle.
  - The compare value is the tx_data of the same frame.
- Not defined: err_cnt is tied to 0 and no comparator logic is synthesised.

Test Plan:
- Single frame, LINK_LAT=64, DEC_LAT=2: data_in=0xA5, tick at cycle 10 -> tx_load at cycle 11, dec_enable at cycle 75, rx_valid at cycle 78 with rx_data equal to the dec_data sampled at cycle 77, frame_cnt=1.
- Overrun: second tick 20 cycles after the first -> overrun=1 stays high, only one tx_load, frame_cnt=1, tx_data keeps the first sample.
- Back-to-back: tick coincident with the rx_valid cycle -> accepted; next tx_load one cycle later; frame_cnt=2 after the second frame; overrun=0.
- Reset mid-LINK: reset low for one cycle at cycle 40 of the link wait -> all outputs 0 the next cycle, no dec_enable, state IDLE, next tick starts a clean frame.
- LOOPBACK_CHECK_EN: tx 0xFF with dec_data forced to 0x0F -> err_cnt=4 at rx_valid. Without the macro, same stimulus -> err_cnt=0.
- Saturation, CNT_W=4: 17 frames -> frame_cnt=15 and held there.
